// File: rtl/axis_fir_param.sv
// Parametrised AXI-Stream direct-form FIR filter.
// Two-stage pipeline: stage 1 registers the per-tap products taken from the
// freshly shifted delay line, stage 2 registers the rounded/saturated sum.
// Coefficients are written into a shadow bank and copied into the active bank
// only between frames, so one frame is always filtered with one bank.
module axis_fir_param #(
  parameter int DATA_W        = 16,
  parameter int COEF_W        = 16,
  parameter int NTAPS         = 15,
  parameter int OUT_W         = 16,
  parameter int SHIFT         = 15,
  parameter int CLEAR_ON_LAST = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [OUT_W-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  output logic [OUT_W/8-1:0]       m_axis_tkeep,
  input  logic                     m_axis_tready,
  input  logic                     coef_wr,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  input  logic                     coef_commit,
  output logic                     coef_pending,
  output logic                     sat_flag
);

  localparam int ADDR_W = $clog2(NTAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = PROD_W + $clog2(NTAPS);
  // One extra bit so the rounding constant can never overflow the sum.
  localparam int RND_W  = ACC_W + 1;

  // Handshake
  logic adv;
  logic accept;

  assign adv           = !m_axis_tvalid | m_axis_tready;
  assign accept        = s_axis_tvalid & adv;
  assign s_axis_tready = adv;

  // Delay line and per-frame clear
  logic signed [DATA_W-1:0] x_q [NTAPS];
  logic signed [DATA_W-1:0] x_d [NTAPS];
  logic                     clear_q;
  logic                     clear_d;
  logic                     frame_open_q;
  logic                     frame_open_d;

  // Coefficient banks
  logic signed [COEF_W-1:0] coef_q   [NTAPS];
  logic signed [COEF_W-1:0] shadow_q [NTAPS];
  logic signed [COEF_W-1:0] shadow_d [NTAPS];
  logic                     pending_q;
  logic                     pending_d;
  logic                     copy;

  // Stage 1
  logic signed [PROD_W-1:0] prod [NTAPS];
  logic signed [PROD_W-1:0] p_q  [NTAPS];
  logic                     v1_q;
  logic                     last1_q;

  // Stage 2
  logic signed [ACC_W-1:0]  sum_c;
  logic signed [RND_W-1:0]  r_c;
  logic [RND_W-OUT_W:0]     top_c;
  logic                     sat_c;
  logic [OUT_W-1:0]         out_c;
  logic [OUT_W-1:0]         m_data_q;
  logic                     m_valid_q;
  logic                     m_last_q;
  logic                     sat_q;

  // The clear pulse lives for exactly the cycle after a tlast beat.
  assign clear_d      = (CLEAR_ON_LAST != 0) & accept & s_axis_tlast;
  assign frame_open_d = accept ? !s_axis_tlast : frame_open_q;

  // Bank swap only in an idle cycle outside a frame, so the active bank
  // seen by every beat of a frame is the same.
  assign copy      = pending_q & !frame_open_q & !accept;
  assign pending_d = pending_q ? !copy : coef_commit;

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign x_d[gi] = accept ? s_axis_tdata : (clear_q ? '0 : x_q[gi]);
      end else begin : g_body
        assign x_d[gi] = clear_q ? '0 : (accept ? x_q[gi-1] : x_q[gi]);
      end
      // Addresses at or beyond NTAPS match no tap and are dropped here.
      assign shadow_d[gi] = (coef_wr && (coef_addr == ADDR_W'(gi))) ? coef_wdata : shadow_q[gi];
      // Products use the post-shift line so the new sample is included.
      assign prod[gi] = PROD_W'(coef_q[gi]) * PROD_W'(x_d[gi]);
    end
  endgenerate

  // Delay line, frame tracking and the one-cycle clear request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      clear_q      <= 1'b0;
      frame_open_q <= 1'b0;
    end else begin
      for (int k = 0; k < NTAPS; k++) x_q[k] <= x_d[k];
      clear_q      <= clear_d;
      frame_open_q <= frame_open_d;
    end
  end

  // Shadow writes every cycle; active bank loads from the post-write shadow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= '0;
        coef_q[k]   <= '0;
      end
      pending_q <= 1'b0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= shadow_d[k];
        if (copy) coef_q[k] <= shadow_d[k];
      end
      pending_q <= pending_d;
    end
  end

  // Stage 1: register products plus valid/tlast, frozen while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) p_q[k] <= '0;
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NTAPS; k++) p_q[k] <= prod[k];
      v1_q    <= accept;
      last1_q <= accept & s_axis_tlast;
    end
  end

  // Full-precision adder tree over the registered products
  always_comb begin
    sum_c = '0;
    for (int k = 0; k < NTAPS; k++) sum_c = sum_c + ACC_W'(p_q[k]);
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RND_W-1:0] RND = {{(RND_W-1){1'b0}}, 1'b1} << (SHIFT-1);
      assign r_c = (RND_W'(sum_c) + RND) >>> SHIFT;
    end else begin : g_noround
      assign r_c = RND_W'(sum_c);
    end
  endgenerate

  // In range only when every bit above the output sign bit matches it.
  assign top_c = r_c[RND_W-1:OUT_W-1];
  assign sat_c = !((&top_c) || !(|top_c));
  assign out_c = sat_c ? {r_c[RND_W-1], {(OUT_W-1){~r_c[RND_W-1]}}} : r_c[OUT_W-1:0];

  // Stage 2: output register and sticky saturation flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else if (adv) begin
      m_valid_q <= v1_q;
      m_last_q  <= last1_q;
      if (v1_q) m_data_q <= out_c;
      sat_q     <= sat_q | (v1_q & sat_c);
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tkeep  = '1;
  assign coef_pending  = pending_q;
  assign sat_flag      = sat_q;

endmodule

// File: doc/axis_fir_param.md
Name: axis_fir_param

Overview:
- Parametrised AXI-Stream direct-form FIR filter; next generation of the fixed 15-tap LPF.
- Adds:
  - generic tap count and widths;
  - run-time coefficient loading with frame-aligned bank switching;
  - true backpressure;
  - rounding and saturation to a narrower output;
  - tlast aligned to its sample;
  - optional per-frame history clear.
- Sits between the ADC/DMA stream source and downstream DSP/DMA sink.

Parameters:
DATA_W, 16, input sample width (signed)
COEF_W, 16, coefficient width (signed)
NTAPS, 15, number of taps (2..64)
OUT_W, 16, output sample width (signed), multiple of 8
SHIFT, 15, arithmetic right shift applied to full-precision sum before rounding
CLEAR_ON_LAST, 0, 1 = zero delay line after each tlast beat

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
s_axis_tdata  in  DATA_W  input sample
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end-of-frame
s_axis_tready  out  1  input ready
m_axis_tdata  out  OUT_W  filtered sample
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  tlast of the input beat that produced this sample
m_axis_tkeep  out  OUT_W/8  all ones
m_axis_tready  in  1  output ready
coef_wr  in  1  shadow coefficient write strobe
coef_addr  in  clog2(NTAPS)  tap index
coef_wdata  in  COEF_W  coefficient value
coef_commit  in  1  request shadow->active copy
coef_pending  out  1  commit requested, not yet applied
sat_flag  out  1  sticky: an output saturated since reset

Behaviour:
Reset (async, reset=0):
- m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, sat_flag=0, coef_pending=0.
- Delay line, pipeline registers, and active and shadow coefficient banks all zero.
- frame_open=0.

Handshake and pipeline:
- adv = !m_axis_tvalid | m_axis_tready.
- s_axis_tready = adv (combinational); 1 after reset.
- Beat accepted when s_axis_tvalid & s_axis_tready.
- On accept: x[0] <= tdata, x[k] <= x[k-1].
- Stage 1 registers products p[k] = c[k]*x[k], computed on the post-shift delay line (new sample included).
- Stage 2 registers sum, rounding and saturation into m_axis_tdata.
- Valid and tlast travel with their stage; all stages hold when adv=0.
- Latency: accept at cycle N gives m_axis_tvalid=1 at N+2 when unstalled. Throughput 1 sample/cycle.
- m_axis_tdata/tlast stable while tvalid=1 and tready=0.
- Bubbles (tvalid=0 input) propagate as invalid stages, never as duplicate outputs.

Arithmetic:
- Full-precision sum width ACC_W = DATA_W+COEF_W+clog2(NTAPS); no internal overflow.
- If SHIFT>0: r = (sum + 2^(SHIFT-1)) >>> SHIFT (round half up). If SHIFT=0: r = sum.
- Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; on clamp, sat_flag <= 1 when the sample enters stage 2.

Coefficients:
- coef_wr writes the shadow bank only; coef_addr >= NTAPS is ignored.
- coef_commit sets coef_pending.
- Copy shadow->active (and clear coef_pending) on the first cycle where coef_pending=1 and frame_open=0 and no beat is accepted that cycle.
- frame_open: set on an accepted beat with tlast=0, cleared on an accepted beat with tlast=1.
- Active bank never changes within a frame.
- coef_wr and coef_commit in the same cycle: the write lands first, then the copy includes it.
- coef_commit while already pending: no additional effect.

CLEAR_ON_LAST=1:
- After the tlast beat is accepted, the delay line is zeroed on the next clock.
- The tlast sample itself uses the full history.
- If a beat is accepted in that same next cycle: x[0] = new sample, x[1..] = 0.

Reset mid-operation:
- All in-flight samples are discarded; no output is produced for beats accepted before reset.

Test Plan:
1. Impulse response: NTAPS=15, SHIFT=0, OUT_W=32, c[k]=k+1, input 1 then 16 zeros, m_axis_tready=1 → outputs 1,2,...,15,0,0; first output valid 2 cycles after the impulse is accepted.
2. Rounding: SHIFT=15, c[0]=0x4000, others 0, inputs 3, -3, 1 → outputs 2, -1, 1.
3. Saturation: all c=0x7FFF, constant input 0x7FFF → outputs settle at 0x7FFF and sat_flag=1; constant input 0x8000 → 0x8000.
4. Backpressure: random m_axis_tready (50%), 200 random samples → output sequence identical to the unstalled golden model; no loss or duplication; data and tlast held stable while stalled.
5. Frame-aligned commit: write a new bank and pulse coef_commit mid-frame (frame_open=1) → coef_pending stays 1 and old coefficients are used until the tlast beat. The next frame's first sample uses the new bank; coef_pending drops before that sample is accepted.
6. CLEAR_ON_LAST=1 plus mid-stream reset: two back-to-back frames → second frame output identical to the same frame run after reset. Assert reset while tvalid is in the pipeline → m_axis_tvalid=0 immediately; no stale output after release.
